// File: rtl/arp_packet_receiver.sv
// GMII receiver for a single minimum-size Ethernet ARP frame: preamble/SFD hunt,
// 60-byte header capture with CRC-32, FCS compare and a one-cycle result pulse.
//
// state    | meaning
// IDLE     | waiting for the first 0x55 of a preamble
// PREAMBLE | counting 0x55 bytes, waiting for SFD 0xD5
// DATA     | capturing post-SFD bytes 0..59, running CRC
// FCS      | assembling the four FCS bytes
// CHECK    | waiting for dv=0 to resolve the frame
// DISCARD  | dropping bytes until dv=0
module arp_packet_receiver #(
  parameter int unsigned PRE_MIN   = 7,
  parameter bit          CHECK_FCS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        arp_valid,
  output logic [15:0] arp_operator,
  output logic [47:0] arp_src_mac,
  output logic [31:0] arp_src_ip,
  output logic [47:0] arp_des_mac,
  output logic [31:0] arp_des_ip,
  output logic        err_crc,
  output logic        err_format,
  output logic        err_length
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, FCS, CHECK, DISCARD} state_t;

  localparam logic [31:0] CRC_POLY_R = 32'hEDB88320;

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY_R) : (r >> 1);
    end
    return r;
  endfunction

  // {must_check, expected_byte} for header bytes 12..19
  function automatic logic [8:0] hdr_exp(input logic [5:0] idx);
    logic [8:0] r;
    case (idx)
      6'd12:   r = 9'h108;
      6'd13:   r = 9'h106;
      6'd14:   r = 9'h100;
      6'd15:   r = 9'h101;
      6'd16:   r = 9'h108;
      6'd17:   r = 9'h100;
      6'd18:   r = 9'h106;
      6'd19:   r = 9'h104;
      default: r = 9'h000;
    endcase
    return r;
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     pre_cnt_q, pre_cnt_d;
  logic [5:0]     byte_cnt_q, byte_cnt_d;
  logic [1:0]     fcs_cnt_q, fcs_cnt_d;
  logic [31:0]    crc_q, crc_d;
  logic [31:0]    fcs_q, fcs_d;
  logic           fmt_err_q, fmt_err_d;
  logic [175:0]   shadow_q, shadow_d;
  logic           valid_q, valid_d;
  logic           err_crc_q, err_crc_d;
  logic           err_fmt_q, err_fmt_d;
  logic           err_len_q, err_len_d;
  logic [15:0]    oper_q, oper_d;
  logic [47:0]    sha_q, sha_d;
  logic [31:0]    spa_q, spa_d;
  logic [47:0]    tha_q, tha_d;
  logic [31:0]    tpa_q, tpa_d;

  logic [8:0]     hdr;
  logic           pre_ok;

  assign hdr    = hdr_exp(byte_cnt_q);
  assign pre_ok = 32'(pre_cnt_q) >= PRE_MIN;

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    byte_cnt_d = byte_cnt_q;
    fcs_cnt_d  = fcs_cnt_q;
    crc_d      = crc_q;
    fcs_d      = fcs_q;
    fmt_err_d  = fmt_err_q;
    shadow_d   = shadow_q;
    valid_d    = 1'b0;
    err_crc_d  = 1'b0;
    err_fmt_d  = 1'b0;
    err_len_d  = 1'b0;
    oper_d     = oper_q;
    sha_d      = sha_q;
    spa_d      = spa_q;
    tha_d      = tha_q;
    tpa_d      = tpa_q;

    case (state_q)
      IDLE: begin
        pre_cnt_d  = 4'd0;
        byte_cnt_d = 6'd0;
        fcs_cnt_d  = 2'd0;
        crc_d      = 32'hFFFF_FFFF;
        fmt_err_d  = 1'b0;
        if (gmii_rx_dv) begin
          if (gmii_rxd == 8'h55) begin
            state_d   = PREAMBLE;
            pre_cnt_d = 4'd1;
          end else begin
            state_d = DISCARD;
          end
        end
      end

      PREAMBLE: begin
        if (!gmii_rx_dv) begin
          state_d = IDLE;
        end else if (gmii_rxd == 8'h55) begin
          if (pre_cnt_q != 4'd15) pre_cnt_d = pre_cnt_q + 4'd1;
        end else if (gmii_rxd == 8'hD5 && pre_ok) begin
          state_d    = DATA;
          byte_cnt_d = 6'd0;
        end else begin
          state_d = DISCARD;
        end
      end

      DATA: begin
        if (!gmii_rx_dv) begin
          err_len_d = 1'b1;
          state_d   = IDLE;
        end else begin
          crc_d = crc_next(crc_q, gmii_rxd);
          if (hdr[8] && (gmii_rxd != hdr[7:0])) fmt_err_d = 1'b1;
          // OPER..TPA are contiguous (bytes 20..41), so one shift register holds them all
          if ((byte_cnt_q >= 6'd20) && (byte_cnt_q <= 6'd41)) begin
            shadow_d = {shadow_q[167:0], gmii_rxd};
          end
          if (byte_cnt_q == 6'd59) begin
            state_d   = FCS;
            fcs_cnt_d = 2'd0;
          end else begin
            byte_cnt_d = byte_cnt_q + 6'd1;
          end
        end
      end

      FCS: begin
        if (!gmii_rx_dv) begin
          err_len_d = 1'b1;
          state_d   = IDLE;
        end else begin
          fcs_d = {gmii_rxd, fcs_q[31:8]};
          if (fcs_cnt_q == 2'd3) state_d = CHECK;
          else                   fcs_cnt_d = fcs_cnt_q + 2'd1;
        end
      end

      CHECK: begin
        if (gmii_rx_dv) begin
          err_len_d = 1'b1;
          state_d   = DISCARD;
        end else begin
          state_d = IDLE;
          if (CHECK_FCS && (fcs_q != ~crc_q)) begin
            err_crc_d = 1'b1;
          end else if (fmt_err_q) begin
            err_fmt_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            {oper_d, sha_d, spa_d, tha_d, tpa_d} = shadow_q;
          end
        end
      end

      DISCARD: begin
        if (!gmii_rx_dv) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pre_cnt_q  <= 4'd0;
      byte_cnt_q <= 6'd0;
      fcs_cnt_q  <= 2'd0;
      crc_q      <= 32'hFFFF_FFFF;
      fcs_q      <= 32'd0;
      fmt_err_q  <= 1'b0;
      shadow_q   <= '0;
      valid_q    <= 1'b0;
      err_crc_q  <= 1'b0;
      err_fmt_q  <= 1'b0;
      err_len_q  <= 1'b0;
      oper_q     <= 16'd0;
      sha_q      <= 48'd0;
      spa_q      <= 32'd0;
      tha_q      <= 48'd0;
      tpa_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      fcs_cnt_q  <= fcs_cnt_d;
      crc_q      <= crc_d;
      fcs_q      <= fcs_d;
      fmt_err_q  <= fmt_err_d;
      shadow_q   <= shadow_d;
      valid_q    <= valid_d;
      err_crc_q  <= err_crc_d;
      err_fmt_q  <= err_fmt_d;
      err_len_q  <= err_len_d;
      oper_q     <= oper_d;
      sha_q      <= sha_d;
      spa_q      <= spa_d;
      tha_q      <= tha_d;
      tpa_q      <= tpa_d;
    end
  end

  assign arp_valid    = valid_q;
  assign err_crc      = err_crc_q;
  assign err_format   = err_fmt_q;
  assign err_length   = err_len_q;
  assign arp_operator = oper_q;
  assign arp_src_mac  = sha_q;
  assign arp_src_ip   = spa_q;
  assign arp_des_mac  = tha_q;
  assign arp_des_ip   = tpa_q;

endmodule

// File: tb/tb_arp_packet_receiver.sv
// Bench for arp_packet_receiver: two DUTs (FCS checked / ignored) share one GMII
// stream; a frame-level model predicts every pulse and the held ARP fields.
module tb_arp_packet_receiver;

  localparam int PRE_MIN = 7;
  localparam int K_NONE = 0, K_VALID = 1, K_CRC = 2, K_FMT = 3, K_LEN = 4;

  typedef logic [7:0] bq_t [$];
  typedef struct {
    int           cyc;
    int           k1;
    int           k0;
    logic [175:0] f;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dv  = 1'b0;
  logic [7:0]  rxd = 8'd0;

  logic        valid_1, crc_1, fmt_1, len_1;
  logic [15:0] op_1;
  logic [47:0] sha_1, tha_1;
  logic [31:0] spa_1, tpa_1;
  logic        valid_0, crc_0, fmt_0, len_0;
  logic [15:0] op_0;
  logic [47:0] sha_0, tha_0;
  logic [31:0] spa_0, tpa_0;

  arp_packet_receiver #(.PRE_MIN(PRE_MIN), .CHECK_FCS(1'b1)) u1 (
    .clk(clk), .rst(rst), .gmii_rx_dv(dv), .gmii_rxd(rxd),
    .arp_valid(valid_1), .arp_operator(op_1), .arp_src_mac(sha_1), .arp_src_ip(spa_1),
    .arp_des_mac(tha_1), .arp_des_ip(tpa_1),
    .err_crc(crc_1), .err_format(fmt_1), .err_length(len_1));

  arp_packet_receiver #(.PRE_MIN(PRE_MIN), .CHECK_FCS(1'b0)) u0 (
    .clk(clk), .rst(rst), .gmii_rx_dv(dv), .gmii_rxd(rxd),
    .arp_valid(valid_0), .arp_operator(op_0), .arp_src_mac(sha_0), .arp_src_ip(spa_0),
    .arp_des_mac(tha_0), .arp_des_ip(tpa_0),
    .err_crc(crc_0), .err_format(fmt_0), .err_length(len_0));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int           n_chk  = 0;
  int           n_fail = 0;
  ev_t          evq[$];
  logic [175:0] m1 = '0, m0 = '0;
  logic [3:0]   p1, p0;
  ev_t          e_cur;

  task automatic chk(input string name, input logic [175:0] act, input logic [175:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] vec(input int k);
    case (k)
      K_VALID: return 4'b1000;
      K_CRC:   return 4'b0100;
      K_FMT:   return 4'b0010;
      K_LEN:   return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  // Textbook form: MSB-first shifter on poly 0x04C11DB7, reflected in and out
  function automatic logic [31:0] crc32(input bq_t d);
    logic [31:0] c, r;
    logic [7:0]  rb;
    logic        fb;
    c = 32'hFFFF_FFFF;
    foreach (d[j]) begin
      rb = rev8(d[j]);
      for (int i = 7; i >= 0; i--) begin
        fb = c[31] ^ rb[i];
        c  = {c[30:0], 1'b0};
        if (fb) c = c ^ 32'h04C11DB7;
      end
    end
    for (int i = 0; i < 32; i++) r[i] = c[31-i];
    return ~r;
  endfunction

  function automatic bq_t build(input int npre, input logic [63:0] hdr_x,
                                input logic [15:0] oper, input logic [47:0] sha,
                                input logic [31:0] spa, input logic [47:0] tha,
                                input logic [31:0] tpa, input logic [47:0] dmac,
                                input logic [47:0] smac);
    bq_t          q, d;
    logic [479:0] v;
    logic [31:0]  c;
    v = {dmac, smac, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
         oper, sha, spa, tha, tpa, 144'd0};
    v = v ^ {96'd0, hdr_x, 320'd0};
    for (int i = 0; i < 60; i++) d.push_back(v[479-8*i -: 8]);
    c = crc32(d);
    for (int i = 0; i < npre; i++) q.push_back(8'h55);
    q.push_back(8'hD5);
    foreach (d[i]) q.push_back(d[i]);
    q.push_back(c[7:0]);
    q.push_back(c[15:8]);
    q.push_back(c[23:16]);
    q.push_back(c[31:24]);
    return q;
  endfunction

  // Outcome of one dv burst: index of the sampled cycle that yields a pulse (-1: none)
  function automatic void predict(input bq_t b, output int idx, output int k1,
                                  output int k0, output logic [175:0] f);
    int          n, d, post;
    bq_t         dat;
    logic [31:0] fcs;
    logic [63:0] hdr;
    logic        bad_fmt, bad_crc;
    idx = -1; k1 = K_NONE; k0 = K_NONE; f = '0; hdr = '0;
    if (b.size() == 0 || b[0] != 8'h55) return;
    n = 0;
    while (n < b.size() && b[n] == 8'h55) n++;
    if (n == b.size()) return;
    if (b[n] != 8'hD5 || ((n > 15) ? 15 : n) < PRE_MIN) return;
    d    = n + 1;
    post = b.size() - d;
    if (post < 64) begin
      idx = b.size(); k1 = K_LEN; k0 = K_LEN; return;
    end
    if (post > 64) begin
      idx = d + 64; k1 = K_LEN; k0 = K_LEN; return;
    end
    for (int i = 0; i < 60; i++) dat.push_back(b[d+i]);
    fcs = {b[d+63], b[d+62], b[d+61], b[d+60]};
    for (int i = 0; i < 8; i++)  hdr = {hdr[55:0], b[d+12+i]};
    for (int i = 0; i < 22; i++) f = {f[167:0], b[d+20+i]};
    bad_fmt = (hdr != 64'h0806_0001_0800_0604);
    bad_crc = (fcs != crc32(dat));
    k1  = bad_crc ? K_CRC : (bad_fmt ? K_FMT : K_VALID);
    k0  = bad_fmt ? K_FMT : K_VALID;
    idx = b.size();
  endfunction

  task automatic send(input bq_t b, input int rst_at, input int gap);
    int           n, base, idx, k1, k0;
    logic [175:0] f;
    bq_t          seg;
    ev_t          e;
    n    = b.size();
    base = 0;
    predict(b, idx, k1, k0, f);
    for (int i = 0; i <= n; i++) begin
      @(posedge clk); #1;
      rst = (i == rst_at);
      if (i < n) begin dv = 1'b1; rxd = b[i]; end
      else       begin dv = 1'b0; rxd = 8'($urandom_range(0, 255)); end
      if (i == rst_at) begin
        seg.delete();
        for (int j = i + 1; j < n; j++) seg.push_back(b[j]);
        base = i + 1;
        predict(seg, idx, k1, k0, f);
      end else if (idx >= 0 && i - base == idx) begin
        e.cyc = cyc + 1; e.k1 = k1; e.k0 = k0; e.f = f;
        evq.push_back(e);
      end
    end
    for (int g = 0; g < gap + 1; g++) begin
      @(posedge clk); #1;
      dv  = 1'b0;
      rxd = 8'($urandom_range(0, 255));
    end
  endtask

  always @(negedge clk) begin
    p1 = 4'd0;
    p0 = 4'd0;
    if (rst) begin
      evq.delete();
      m1 = '0;
      m0 = '0;
    end else if (evq.size() > 0 && evq[0].cyc == cyc) begin
      e_cur = evq.pop_front();
      p1 = vec(e_cur.k1);
      p0 = vec(e_cur.k0);
      if (e_cur.k1 == K_VALID) m1 = e_cur.f;
      if (e_cur.k0 == K_VALID) m0 = e_cur.f;
    end
    chk("d1_pulses", 176'({valid_1, crc_1, fmt_1, len_1}), 176'(p1));
    chk("d1_fields", {op_1, sha_1, spa_1, tha_1, tpa_1}, m1);
    chk("d0_pulses", 176'({valid_0, crc_0, fmt_0, len_0}), 176'(p0));
    chk("d0_fields", {op_0, sha_0, spa_0, tha_0, tpa_0}, m0);
  end

  initial begin
    bq_t          fr, fx;
    int           idx, k1, k0, typ, npre, len;
    logic [175:0] f;
    logic [63:0]  hx;

    fr = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("crc_pin", 176'(crc32(fr)), 176'(32'hCBF43926));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    fr = build(7, 64'd0, 16'h0001, 48'h001122334455, 32'hC0A80001, 48'd0,
               32'hC0A80002, 48'hFFFF_FFFF_FFFF, 48'h001122334455);
    predict(fr, idx, k1, k0, f);
    chk("pin_kind", 176'(k1), 176'(K_VALID));
    chk("pin_idx",  176'(idx), 176'(72));
    chk("pin_fields", f, {16'h0001, 48'h001122334455, 32'hC0A80001, 48'd0, 32'hC0A80002});
    send(fr, -1, 2);
    chk("dir_oper",   176'(op_1),  176'(16'h0001));
    chk("dir_src_ip", 176'(spa_1), 176'(32'hC0A80001));
    chk("dir_des_ip", 176'(tpa_1), 176'(32'hC0A80002));
    chk("dir_src_mac", 176'(sha_1), 176'(48'h001122334455));

    fx = fr;
    fx[69] = fx[69] ^ 8'h01;
    predict(fx, idx, k1, k0, f);
    chk("pin_crc_k1", 176'(k1), 176'(K_CRC));
    chk("pin_crc_k0", 176'(k0), 176'(K_VALID));
    send(fx, -1, 1);

    fx = build(7, {16'h0006, 48'd0}, 16'h0002, 48'hAABBCCDDEEFF, 32'h0A000001, 48'h1,
               32'h0A000002, 48'hFFFF_FFFF_FFFF, 48'hAABBCCDDEEFF);
    send(fx, -1, 1);
    chk("fmt_hold_src_ip", 176'(spa_1), 176'(32'hC0A80001));

    fx.delete();
    for (int i = 0; i < 39; i++) fx.push_back(fr[i]);
    send(fx, -1, 0);
    send(fr, -1, 1);

    fx = build(5, 64'd0, 16'h0001, 48'h001122334455, 32'hC0A80001, 48'd0,
               32'hC0A80002, 48'hFFFF_FFFF_FFFF, 48'h001122334455);
    send(fx, -1, 1);
    fx = fr;
    fx.push_back(8'h00);
    send(fx, -1, 1);

    send(fr, 48, 2);
    chk("rst_src_ip", 176'(spa_1), 176'(0));
    send(fr, -1, 1);
    chk("post_rst_src_ip", 176'(spa_1), 176'(32'hC0A80001));

    repeat (150) begin
      typ  = $urandom_range(0, 7);
      npre = (typ == 6) ? $urandom_range(1, 6) : $urandom_range(7, 12);
      hx   = (typ == 3) ? (64'd1 << $urandom_range(0, 63)) : 64'd0;
      fr = build(npre, hx, 16'($urandom_range(1, 2)),
                 48'({$urandom(), $urandom()}), $urandom(),
                 48'({$urandom(), $urandom()}), $urandom(),
                 48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}));
      case (typ)
        2: begin
          idx = fr.size() - 1 - $urandom_range(0, 3);
          fr[idx] = fr[idx] ^ 8'($urandom_range(1, 255));
        end
        4: begin
          len = npre + 1 + $urandom_range(0, 63);
          while (fr.size() > len) void'(fr.pop_back());
        end
        5: repeat ($urandom_range(1, 3)) fr.push_back(8'($urandom_range(0, 255)));
        6: if ($urandom_range(0, 1) == 1) begin
          fr.delete();
          repeat ($urandom_range(1, 20)) fr.push_back(8'($urandom_range(0, 255)));
        end
        default: ;
      endcase
      if (typ == 7) send(fr, $urandom_range(npre + 1, fr.size() - 1), $urandom_range(0, 3));
      else          send(fr, -1, $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("events_drained", 176'(evq.size()), 176'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
